// File: rtl/hazard_if.sv
// -----------------------------------------------------------------------------
// hazard_if
// Bundles every pipeline-facing signal of the hazard controller.
//   master : pipeline side. Drives register addresses and status, and receives
//            the stall, flush and forward controls.
//   slave  : hazard_unit side.
// All signals are level-sensitive and are evaluated every cycle. There is no
// valid/ready handshake: a control output applies to the cycle in which it is
// asserted.
// Signals:
//   Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW           register addresses (5b)
//   MemReadE, PCSrcE, RegWriteM, MemBusyM, RegWriteW  stage status bits
//   StallF/D/E/M, FlushD/E                          pipeline register controls
//   ForwardAE/BE                                    EX operand selects (2b)
//   MemTimeout                                      sticky watchdog flag
//   StallCycles, FlushEvents                        perf counters (32b, 0 when
//                                                   the counters are built out)
// -----------------------------------------------------------------------------
interface hazard_if;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic        MemReadE;
    logic        PCSrcE;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic        MemBusyM;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic        StallF;
    logic        StallD;
    logic        StallE;
    logic        StallM;
    logic        FlushD;
    logic        FlushE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic        MemTimeout;
    logic [31:0] StallCycles;
    logic [31:0] FlushEvents;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, PCSrcE,
               RdM, RegWriteM, MemBusyM, RdW, RegWriteW,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE,
               ForwardAE, ForwardBE, MemTimeout, StallCycles, FlushEvents
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, PCSrcE,
               RdM, RegWriteM, MemBusyM, RdW, RegWriteW,
        output StallF, StallD, StallE, StallM, FlushD, FlushE,
               ForwardAE, ForwardBE, MemTimeout, StallCycles, FlushEvents
    );
endinterface

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard controller for the 5-stage RISC-V core: post-reset flush
// sequencer, load-use / redirect / memory-wait stall logic with a timeout
// watchdog, and EX-stage forwarding selects.
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   hz           hazard_if.slave bundle (addresses, status, controls)
//   o_dbg_state  FSM state (0 = INIT, 1 = RUN, 2 = WAIT)
// Parameters:
//   RESET_FLUSH_CYCLES  cycles FlushD/FlushE stay high after reset (1..15)
//   MAX_WAIT            MemBusyM cycles allowed before MemTimeout sets (1..255)
// Optional feature macro: HAZARD_PERF_CNT_EN builds the StallCycles and
// FlushEvents counters. Without it both outputs are tied to zero.
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int RESET_FLUSH_CYCLES = 2,
    parameter int MAX_WAIT           = 64
) (
    input  logic       clk,
    input  logic       rst,
    hazard_if.slave    hz,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(RESET_FLUSH_CYCLES);
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_flush_cnt;
    logic [7:0] r_wait_cnt;
    logic       r_timeout;

    logic       w_active;
    logic       w_load_use;
    logic [7:0] w_wait_inc;
    logic       w_timeout_hit;
    logic       w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic       w_flush_d, w_flush_e;
    logic [1:0] w_fwd_a, w_fwd_b;

    assign w_active   = !rst && (r_state == ST_RUN || r_state == ST_WAIT);
    assign w_load_use = hz.MemReadE && (hz.RdE != 5'd0) &&
                        (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);

    // Value the wait counter takes if MemBusyM stays high this cycle: entering
    // WAIT from RUN loads 1, otherwise increment and saturate at 255.
    assign w_wait_inc = (r_state == ST_RUN) ? 8'd1 :
                        (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;

    assign w_timeout_hit = w_active && hz.MemBusyM && (w_wait_inc >= WAIT_LIMIT);

    // State register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_flush_cnt <= FLUSH_INIT;
            r_wait_cnt  <= 8'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_INIT && r_flush_cnt != 4'd0)
                r_flush_cnt <= r_flush_cnt - 4'd1;
            if (w_active && hz.MemBusyM)
                r_wait_cnt <= w_wait_inc;
            else
                r_wait_cnt <= 8'd0;
            if (w_timeout_hit)
                r_timeout <= 1'b1;
        end
    end

    // Next-state logic. INIT leaves on the cycle the counter shows 1, so the
    // flush is visible for exactly RESET_FLUSH_CYCLES cycles.
    always_comb begin
        w_next_state = ST_INIT;
        case (r_state)
            ST_INIT: w_next_state = (r_flush_cnt <= 4'd1) ? ST_RUN : ST_INIT;
            ST_RUN:  w_next_state = hz.MemBusyM ? ST_WAIT : ST_RUN;
            ST_WAIT: w_next_state = hz.MemBusyM ? ST_WAIT : ST_RUN;
            default: w_next_state = ST_INIT;
        endcase
    end

    // Output logic. A busy memory freezes everything in both RUN and WAIT; the
    // cycle MemBusyM drops in WAIT falls through to the RUN rules directly.
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_fwd_a   = 2'b00;
        w_fwd_b   = 2'b00;
        if (!w_active) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else begin
            if (hz.MemBusyM) begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_stall_e = 1'b1;
                w_stall_m = 1'b1;
            end else if (hz.PCSrcE) begin
                w_flush_d = 1'b1;
                w_flush_e = 1'b1;
            end else if (w_load_use) begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_flush_e = 1'b1;
            end
            // M beats W; x0 is never forwarded.
            if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)
                w_fwd_a = 2'b10;
            else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E)
                w_fwd_a = 2'b01;
            if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)
                w_fwd_b = 2'b10;
            else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E)
                w_fwd_b = 2'b01;
        end
    end

    assign hz.StallF     = w_stall_f;
    assign hz.StallD     = w_stall_d;
    assign hz.StallE     = w_stall_e;
    assign hz.StallM     = w_stall_m;
    assign hz.FlushD     = w_flush_d;
    assign hz.FlushE     = w_flush_e;
    assign hz.ForwardAE  = w_fwd_a;
    assign hz.ForwardBE  = w_fwd_b;
    assign hz.MemTimeout = r_timeout;
    assign o_dbg_state   = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_events <= 32'd0;
        end else begin
            if (w_active && w_stall_f)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            // Counts only flushes caused by a redirect, not by a freeze.
            if (w_active && !hz.MemBusyM && hz.PCSrcE)
                r_flush_events <= r_flush_events + 32'd1;
        end
    end

    assign hz.StallCycles = r_stall_cycles;
    assign hz.FlushEvents = r_flush_events;
`else
    assign hz.StallCycles = 32'd0;
    assign hz.FlushEvents = 32'd0;
`endif

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline hazard controller for the 5-stage RISC-V core. It drives the stall and flush inputs of the fetch/decode, decode/execute and execute/memory pipeline registers, and generates the EX-stage forwarding selects. Sequential elements:
- a post-reset flush sequencer
- a memory-wait FSM with a timeout watchdog
- optional performance counters

Parameters:
- RESET_FLUSH_CYCLES, 2, number of cycles FlushD/FlushE are held after reset deasserts (1..15)
- MAX_WAIT, 64, number of MemBusyM cycles allowed before MemTimeout sets (1..255)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous active-high reset
- Rs1D, Rs2D  input  5  decode-stage source register addresses
- Rs1E, Rs2E, RdE  input  5  execute-stage register addresses
- MemReadE  input  1  load instruction in EX
- PCSrcE  input  1  taken branch/jump redirect resolved in EX
- RdM  input  5  memory-stage destination
- RegWriteM  input  1  memory-stage writes rd
- MemBusyM  input  1  data memory not ready; freeze pipeline
- RdW  input  5  writeback-stage destination
- RegWriteW  input  1  writeback-stage writes rd
- StallF, StallD, StallE, StallM  output  1  hold PC / IF-ID / ID-EX / EX-MEM
- FlushD, FlushE  output  1  bubble IF-ID / ID-EX
- ForwardAE, ForwardBE  output  2  00 = register file, 10 = ALU result from M, 01 = result from W
- MemTimeout  output  1  sticky watchdog error flag

Behaviour:
- FSM states: INIT, RUN, WAIT. The state register, flush counter (4b), wait counter (8b) and MemTimeout all use synchronous reset.
- rst=1 at posedge:
  - state<=INIT, flush counter<=RESET_FLUSH_CYCLES, wait counter<=0, MemTimeout<=0.
- Outputs are combinational from state and inputs.
  - While rst is high or state=INIT: FlushD=FlushE=1, all stalls 0, ForwardAE/BE=00.
- INIT:
  - Counter decrements each cycle.
  - Go to RUN on the cycle after the counter reaches 1, so the flush is seen for exactly RESET_FLUSH_CYCLES cycles after the rst falling edge.
- RUN, priority high to low:
  1. MemBusyM=1: StallF=StallD=StallE=StallM=1, FlushD=FlushE=0. Next state WAIT; wait counter<=1.
  2. PCSrcE=1: FlushD=FlushE=1, no stall. Redirect beats load-use in the same cycle.
  3. Load-use: MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D). StallF=StallD=1, FlushE=1, StallE=StallM=0. This is a single-cycle bubble; the next cycle re-evaluates normally.
  4. Otherwise all stalls and flushes are 0.
- WAIT:
  - All four stalls are 1; flushes are 0. PCSrcE is ignored because EX is frozen and PCSrcE is held stable.
  - Wait counter increments and saturates at 255.
  - When the counter reaches MAX_WAIT with MemBusyM still 1, MemTimeout<=1. It stays set until rst.
  - MemBusyM=0: that same cycle outputs follow the RUN rules (no dead cycle); next state RUN, wait counter<=0.
- Forwarding (states RUN and WAIT), evaluated identically for the B side with Rs2E:
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E
  - else 00
  - M has priority over W. x0 is never forwarded.
- Reset mid-WAIT: rst overrides; the next state is INIT and MemTimeout clears.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs StallCycles[31:0] and FlushEvents[31:0], both cleared by rst.
  - StallCycles increments each RUN/WAIT cycle in which StallF=1.
  - FlushEvents increments each RUN cycle in which PCSrcE caused a flush.
  - Both wrap modulo 2^32.
- Undefined: the ports still exist, tied to 0, with no counter flops.

Test Plan:
- Reset release with RESET_FLUSH_CYCLES=2 -> FlushD=FlushE=1 for exactly 2 cycles after rst falls, then 0; all stalls 0 throughout.
- Load-use: MemReadE=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for one cycle. With RdE=0 -> no stall.
- Redirect and load-use in the same cycle (PCSrcE=1, MemReadE=1, RdE=Rs2D=7) -> FlushD=FlushE=1, StallF=0.
- Forwarding: RegWriteM=1, RdM=3, RegWriteW=1, RdW=3, Rs1E=3 -> ForwardAE=10. Drop RegWriteM -> 01. Rs1E=0 with RdM=0 -> 00.
- MemBusyM held 3 cycles -> all stalls 1 for 3 cycles, RUN resumes with no gap, MemTimeout=0. Held 64 cycles with MAX_WAIT=64 -> MemTimeout=1, stays 1 after MemBusyM drops, clears only on rst.
- rst asserted mid-WAIT with MemTimeout=1 -> next cycle in INIT, flushes 1, MemTimeout=0. With HAZARD_PERF_CNT_EN defined, StallCycles and FlushEvents read 0.
